// File: rtl/ultrasonic_echo_responder.sv
// rtl/ultrasonic_echo_responder.sv - HC-SR04-style sensor emulator
// Qualifies a trigger pulse, waits a burst delay, then drives an echo whose width encodes range_cm.
module ultrasonic_echo_responder #(
  parameter int TRIG_MIN_CYC    = 500,
  parameter int BURST_DELAY_CYC = 25000,
  parameter int CM_CYC          = 2900,
  parameter int TIMEOUT_CYC     = 1900000,
  parameter int HOLDOFF_CYC     = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [7:0] range_cm,
  input  logic       no_object,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic [7:0] echo_count
);

  localparam int DMAX = (TIMEOUT_CYC > BURST_DELAY_CYC) ?
                        ((TIMEOUT_CYC > HOLDOFF_CYC) ? TIMEOUT_CYC : HOLDOFF_CYC) :
                        ((BURST_DELAY_CYC > HOLDOFF_CYC) ? BURST_DELAY_CYC : HOLDOFF_CYC);
  localparam int DW = $clog2(DMAX + 1);
  localparam int WW = $clog2(TRIG_MIN_CYC + 1);
  localparam int SW = $clog2(CM_CYC + 1);

  localparam logic [WW-1:0] TRIG_MIN     = WW'(TRIG_MIN_CYC);
  localparam logic [DW-1:0] BURST_LAST   = DW'(BURST_DELAY_CYC - 1);
  localparam logic [DW-1:0] TIMEOUT_LAST = DW'(TIMEOUT_CYC - 1);
  localparam logic [DW-1:0] HOLD_LAST    = DW'(HOLDOFF_CYC - 1);
  localparam logic [SW-1:0] SUB_LAST     = SW'(CM_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG_HI, S_BURST, S_ECHO, S_HOLDOFF
  } state_t;

  state_t state, next_state;

  logic          trig_m, trig_s, trig_d;
  logic [WW-1:0] wcnt;
  logic [DW-1:0] dcnt;
  logic [SW-1:0] sub_cnt;
  logic [7:0]    cm_cnt;
  logic          obj_none;
  logic          short_trig, echo_done;
  logic          echo_nxt, busy_nxt, err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      trig_m <= trigger;
      trig_s <= trig_m;
      trig_d <= trig_s;
    end
  end

  assign short_trig = (wcnt < TRIG_MIN);
  // Width = cm_cnt whole centimetres, each CM_CYC sub-counter cycles long.
  assign echo_done  = obj_none ? (dcnt == TIMEOUT_LAST)
                               : ((sub_cnt == SUB_LAST) && (cm_cnt == 8'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (trig_s && !trig_d) next_state = S_TRIG_HI;
      S_TRIG_HI: if (!trig_s) next_state = short_trig ? S_IDLE : S_BURST;
      S_BURST:   if (dcnt == BURST_LAST) next_state = S_ECHO;
      S_ECHO:    if (echo_done) next_state = S_HOLDOFF;
      S_HOLDOFF: if (dcnt == HOLD_LAST) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    echo_nxt = (next_state == S_ECHO);
    busy_nxt = (next_state != S_IDLE);
    err_nxt  = (state == S_TRIG_HI) && !trig_s && short_trig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo       <= 1'b0;
      busy       <= 1'b0;
      trig_err   <= 1'b0;
      echo_count <= 8'd0;
    end else begin
      echo     <= echo_nxt;
      busy     <= busy_nxt;
      trig_err <= err_nxt;
      if (state == S_ECHO && next_state == S_HOLDOFF) echo_count <= echo_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt     <= '0;
      dcnt     <= '0;
      sub_cnt  <= '0;
      cm_cnt   <= 8'd0;
      obj_none <= 1'b0;
    end else begin
      if (state == S_IDLE) wcnt <= WW'(1);
      else if (state == S_TRIG_HI && trig_s && short_trig) wcnt <= wcnt + WW'(1);

      // dcnt is shared by BURST, timeout ECHO and HOLDOFF; it restarts on every state change.
      if (state != next_state) dcnt <= '0;
      else if (state == S_BURST || state == S_HOLDOFF || (state == S_ECHO && obj_none))
        dcnt <= dcnt + DW'(1);

      if (state != S_ECHO || sub_cnt == SUB_LAST) sub_cnt <= '0;
      else sub_cnt <= sub_cnt + SW'(1);

      if (state == S_TRIG_HI && next_state == S_BURST) begin
        cm_cnt   <= (range_cm == 8'd0) ? 8'd1 : range_cm;
        obj_none <= no_object;
      end else if (state == S_ECHO && !obj_none && sub_cnt == SUB_LAST && cm_cnt != 8'd1) begin
        cm_cnt <= cm_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// tb/tb_ultrasonic_echo_responder.sv - directed self-checking bench for ultrasonic_echo_responder
// Scaled-down timing parameters keep every scenario short.
module tb_ultrasonic_echo_responder;

  localparam int TMIN  = 8;
  localparam int BURST = 20;
  localparam int CM    = 5;
  localparam int TOUT  = 300;
  localparam int HOLD  = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic [7:0] range_cm;
  logic       no_object;
  logic       echo, busy, trig_err;
  logic [7:0] echo_count;

  int errors = 0;
  int checks = 0;

  ultrasonic_echo_responder #(
    .TRIG_MIN_CYC(TMIN), .BURST_DELAY_CYC(BURST), .CM_CYC(CM),
    .TIMEOUT_CYC(TOUT), .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .range_cm(range_cm),
    .no_object(no_object), .echo(echo), .busy(busy), .trig_err(trig_err),
    .echo_count(echo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input int n);
    @(negedge clk);
    trigger = 1'b1;
    repeat (n) @(negedge clk);
    trigger = 1'b0;
  endtask

  // Follows a valid pulse: echo must rise BURST cycles after BURST entry and last w cycles.
  task automatic expect_echo(input int w, input int cnt);
    repeat (2 + BURST) @(negedge clk);
    range_cm  = range_cm ^ 8'hFF;
    no_object = ~no_object;
    chk("pre_echo_low", int'(echo), 0);
    chk("busy_burst", int'(busy), 1);
    @(negedge clk);
    chk("echo_rise", int'(echo), 1);
    repeat (w - 1) @(negedge clk);
    chk("echo_last_high", int'(echo), 1);
    @(negedge clk);
    chk("echo_fall", int'(echo), 0);
    chk("echo_count", int'(echo_count), cnt);
    repeat (HOLD - 1) @(negedge clk);
    chk("busy_holdoff", int'(busy), 1);
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int highs, rises, errs;
    logic prev;
    rst = 1'b1; trigger = 1'b0; range_cm = 8'd0; no_object = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(trig_err), 0);
    chk("rst_count", int'(echo_count), 0);
    rst = 1'b0;

    range_cm = 8'd10; no_object = 1'b0;
    pulse(12);
    expect_echo(50, 1);

    pulse(TMIN - 1);
    repeat (2) @(negedge clk);
    chk("err_not_yet", int'(trig_err), 0);
    @(negedge clk);
    chk("err_pulse", int'(trig_err), 1);
    chk("err_busy_low", int'(busy), 0);
    @(negedge clk);
    chk("err_one_cycle", int'(trig_err), 0);
    highs = 0;
    repeat (BURST + 20) begin
      @(negedge clk);
      if (echo) highs++;
    end
    chk("err_no_echo", highs, 0);
    chk("err_count", int'(echo_count), 1);

    range_cm = 8'd3; no_object = 1'b0;
    pulse(TMIN);
    expect_echo(15, 2);

    range_cm = 8'd7; no_object = 1'b1;
    pulse(TMIN);
    expect_echo(TOUT, 3);

    range_cm = 8'd0; no_object = 1'b0;
    pulse(TMIN);
    expect_echo(CM, 4);

    range_cm = 8'd10; no_object = 1'b0;
    pulse(TMIN);
    highs = 0; rises = 0; errs = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      trigger = ((i >= 40 && i < 55) || (i >= 80 && i < 90) || i >= 95);
      @(negedge clk);
      if (echo && !prev) rises++;
      if (echo) highs++;
      if (trig_err) errs++;
      prev = echo;
    end
    chk("retrig_rises", rises, 1);
    chk("retrig_width", highs, 50);
    chk("retrig_no_err", errs, 0);
    chk("retrig_count", int'(echo_count), 5);
    chk("held_trig_idle", int'(busy), 0);
    trigger = 1'b0;
    range_cm = 8'd6; no_object = 1'b0;
    pulse(TMIN);
    expect_echo(30, 6);

    range_cm = 8'd255; no_object = 1'b0;
    pulse(TMIN);
    repeat (2 + BURST + 100) @(negedge clk);
    chk("mid_echo_high", int'(echo), 1);
    #3 rst = 1'b1;
    #1;
    chk("rst_echo_async", int'(echo), 0);
    chk("rst_count_async", int'(echo_count), 0);
    chk("rst_busy_async", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    range_cm = 8'd2; no_object = 1'b0;
    pulse(TMIN);
    expect_echo(10, 1);

    for (int k = 2; k <= 256; k++) begin
      range_cm = 8'd1; no_object = 1'b0;
      pulse(TMIN);
      expect_echo(CM, k % 256);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
